ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor that replaces the fixed 32-bit, per-stage prefix modules with a single generated block.
- Supports any WIDTH and configurable register placement between prefix levels.
- Supports add or subtract per operation.
- Carries a valid/ready handshake plus a sideband tag.
- Sits in the FFT butterfly datapath ahead of the twiddle multiplier and rounding stages.

---
 rtl/ks_pkg.sv | 30 +++
 rtl/ks_prefix_level.sv | 57 +++++
 rtl/ks_adder_pipe.sv | 115 +++++++++++
 tb/tb_ks_adder_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   function automatic int ks_levels(input int width);
      return clog2(width);
   endfunction

   function automatic int ks_nreg(input int width, input int reg_every);
      return (ks_levels(width) + reg_every - 1) / reg_every;
   endfunction

   function automatic int ks_latency(input int width, input int reg_every);
      return ks_nreg(width, reg_every) + 2;
   endfunction

   // Per-operation scalars that ride alongside the prefix tree.
   typedef struct packed {
      logic cin;
      logic a_msb;
      logic b_msb;
   } ks_side_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level at distance DIST, plus its cells.
module grey_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   output logic g
);
   assign g = g_hi | (p_hi & g_lo);
endmodule

module black_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);
   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;
endmodule

module ks_prefix_level #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);
   // Carry-in is folded into bit 0, so positions below DIST are already final
   // and positions below 2*DIST become final here (grey cell suffices).
   for (genvar j = 0; j < WIDTH; j++) begin : g_pos
      if (j < DIST) begin : g_pass
         assign g_out[j] = g_in[j];
         assign p_out[j] = p_in[j];
      end else if (j < 2 * DIST) begin : g_grey
         grey_cell u_grey (
            .g_hi (g_in[j]),
            .p_hi (p_in[j]),
            .g_lo (g_in[j-DIST]),
            .g    (g_out[j])
         );
         assign p_out[j] = p_in[j];
      end else begin : g_black
         black_cell u_black (
            .g_hi (g_in[j]),
            .p_hi (p_in[j]),
            .g_lo (g_in[j-DIST]),
            .p_lo (p_in[j-DIST]),
            .g    (g_out[j]),
            .p    (p_out[j])
         );
      end
   end
endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and tag.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c0,
   input  logic             i_sub,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_c_out,
   output logic             o_ovf,
   output logic [TAG_W-1:0] o_tag
);
   localparam int LEVELS = ks_levels(WIDTH);
   localparam int NREG   = ks_nreg(WIDTH, REG_EVERY);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] p_save;
      ks_side_t         side;
      logic [TAG_W-1:0] tag;
   } stage_t;

   logic            adv;
   logic [NREG+1:0] vld_pipe;
   logic [WIDTH-1:0] b_eff, pp, gg;
   logic             cin;
   stage_t           p_d, p_q;
   stage_t           stg [LEVELS+1];

   assign adv     = ~o_valid | i_ready;
   assign o_ready = adv;
   assign o_valid = vld_pipe[NREG+1];

   // Valid bits shift with the global enable, bubbles included.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[NREG:0], i_valid};
   end

   always_comb begin
      b_eff = i_sub ? ~i_b : i_b;
      cin   = i_sub ? 1'b1 : i_c0;
      pp    = i_a ^ b_eff;
      gg    = i_a & b_eff;
      // Position -1 (carry-in) is merged into bit 0 up front.
      gg[0] = gg[0] | (pp[0] & cin);
      p_d   = '{g: gg, p: pp, p_save: pp,
                side: '{cin: cin, a_msb: i_a[WIDTH-1], b_msb: b_eff[WIDTH-1]},
                tag: i_tag};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) p_q <= '0;
      else if (adv) p_q <= p_d;
   end

   assign stg[0] = p_q;

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      logic [WIDTH-1:0] g_o, p_o;
      stage_t           lout;

      ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
         .g_in  (stg[k].g),
         .p_in  (stg[k].p),
         .g_out (g_o),
         .p_out (p_o)
      );
      assign lout = {g_o, p_o, stg[k].p_save, stg[k].side, stg[k].tag};

      if (((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1)) begin : g_reg
         stage_t q;
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) q <= '0;
            else if (adv) q <= lout;
         end
         assign stg[k+1] = q;
      end else begin : g_comb
         assign stg[k+1] = lout;
      end
   end

   logic [WIDTH-1:0] sum;
   stage_t           fin;

   assign fin = stg[LEVELS];
   assign sum = fin.p_save ^ {fin.g[WIDTH-2:0], fin.side.cin};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sum   <= '0;
         o_c_out <= 1'b0;
         o_ovf   <= 1'b0;
         o_tag   <= '0;
      end else if (adv) begin
         o_sum   <= sum;
         o_c_out <= fin.g[WIDTH-1];
         o_ovf   <= (fin.side.a_msb == fin.side.b_msb) & (sum[WIDTH-1] != fin.side.a_msb);
         o_tag   <= fin.tag;
      end
   end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: scoreboard against an arithmetic model, two configs.
module tb_ks_adder_pipe;
   import ks_pkg::*;

   localparam int W   = 32, RE  = 1, TW  = 8;
   localparam int W2  = 24, RE2 = 2, TW2 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, i_valid, o_ready, i_c0, i_sub, o_valid, i_ready, o_c_out, o_ovf;
   logic [W-1:0]  i_a, i_b, o_sum;
   logic [TW-1:0] i_tag, o_tag;

   logic           rst2, v2, ordy2, c02, sub2, ov2_valid, rdy2, co2, ovf2;
   logic [W2-1:0]  a2, b2, sum2;
   logic [TW2-1:0] tag2, otag2;

   ks_adder_pipe #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(TW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_c0(i_c0), .i_sub(i_sub), .i_tag(i_tag),
      .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_c_out(o_c_out),
      .o_ovf(o_ovf), .o_tag(o_tag));

   ks_adder_pipe #(.WIDTH(W2), .REG_EVERY(RE2), .TAG_W(TW2)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_valid(v2), .o_ready(ordy2),
      .i_a(a2), .i_b(b2), .i_c0(c02), .i_sub(sub2), .i_tag(tag2),
      .o_valid(ov2_valid), .i_ready(rdy2), .o_sum(sum2), .o_c_out(co2),
      .o_ovf(ovf2), .o_tag(otag2));

   int checks = 0, failures = 0;
   logic done2 = 1'b0;

   typedef struct {
      logic [63:0] s;
      logic        co;
      logic        ov;
      logic [7:0]  tag;
   } exp_t;

   exp_t q1[$], q2[$];

   // Plain modular arithmetic plus signed range test.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic c0, input logic sub, input logic [7:0] tag);
      exp_t        e;
      logic [63:0] m, am, bm;
      logic [64:0] t;
      longint      sa, sb, r, half;
      m    = (64'd1 << w) - 64'd1;
      am   = a & m;
      bm   = b & m;
      half = longint'(1) << (w - 1);
      sa   = am[w-1] ? longint'(am) - (longint'(1) << w) : longint'(am);
      sb   = bm[w-1] ? longint'(bm) - (longint'(1) << w) : longint'(bm);
      if (sub) begin
         t    = {1'b0, am} - {1'b0, bm};
         e.co = (am >= bm);
         r    = sa - sb;
      end else begin
         t    = {1'b0, am} + {1'b0, bm} + {64'd0, c0};
         e.co = t[w];
         r    = sa + sb + longint'(c0);
      end
      e.s   = t[63:0] & m;
      e.ov  = (r >= half) || (r < -half);
      e.tag = tag;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event", nm);
   endtask

   task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic c0, input logic sub,
                      input logic [31:0] s, input logic co, input logic ov);
      exp_t e;
      e = model(32, {32'd0, a}, {32'd0, b}, c0, sub, 8'd0);
      chk({nm, "_sum"}, e.s, {32'd0, s});
      chk({nm, "_co"}, {63'd0, e.co}, {63'd0, co});
      chk({nm, "_ovf"}, {63'd0, e.ov}, {63'd0, ov});
   endtask

   // Main-DUT monitor: scoreboard, stall hold and stall ready.
   logic          hold1 = 1'b0;
   logic [W-1:0]  h_sum;
   logic [TW-1:0] h_tag;
   always @(negedge clk) begin
      if (rst) begin
         hold1 <= 1'b0;
      end else begin
         if (hold1) begin
            chk("hold_valid", {63'd0, o_valid}, 64'd1);
            chk("hold_sum", {32'd0, o_sum}, {32'd0, h_sum});
            chk("hold_tag", {56'd0, o_tag}, {56'd0, h_tag});
         end
         if (i_valid && o_ready)
            q1.push_back(model(W, {32'd0, i_a}, {32'd0, i_b}, i_c0, i_sub, i_tag));
         if (o_valid && i_ready) begin
            if (q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_result actual=tag %0h expected=none", o_tag);
            end else begin
               chk("sum", {32'd0, o_sum}, q1[0].s);
               chk("c_out", {63'd0, o_c_out}, {63'd0, q1[0].co});
               chk("ovf", {63'd0, o_ovf}, {63'd0, q1[0].ov});
               chk("tag", {56'd0, o_tag}, {56'd0, q1[0].tag});
               void'(q1.pop_front());
            end
         end
         if (o_valid && !i_ready) chk("stall_ready", {63'd0, o_ready}, 64'd0);
         hold1 <= o_valid && !i_ready;
         h_sum <= o_sum;
         h_tag <= o_tag;
      end
   end

   always @(negedge clk) begin
      if (!rst2) begin
         if (v2 && ordy2)
            q2.push_back(model(W2, {40'd0, a2}, {40'd0, b2}, c02, sub2, {4'd0, tag2}));
         if (ov2_valid && rdy2) begin
            if (q2.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_result2 actual=tag %0h expected=none", otag2);
            end else begin
               chk("sum2", {40'd0, sum2}, q2[0].s);
               chk("c_out2", {63'd0, co2}, {63'd0, q2[0].co});
               chk("ovf2", {63'd0, ovf2}, {63'd0, q2[0].ov});
               chk("tag2", {60'd0, otag2}, {56'd0, q2[0].tag});
               void'(q2.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                        input logic sub, input logic [TW-1:0] tag);
      int   n;
      logic ok;
      n = 0;
      i_a = a; i_b = b; i_c0 = c0; i_sub = sub; i_tag = tag; i_valid = 1'b1;
      do begin
         @(negedge clk); ok = o_ready;
         @(posedge clk); #1; n++;
      end while (!ok && n < 100);
      if (!ok) fail_now("issue_timeout");
      i_valid = 1'b0;
   endtask

   task automatic issue2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c0,
                         input logic sub, input logic [TW2-1:0] tag);
      int   n;
      logic ok;
      n = 0;
      a2 = a; b2 = b; c02 = c0; sub2 = sub; tag2 = tag; v2 = 1'b1;
      do begin
         @(negedge clk); ok = ordy2;
         @(posedge clk); #1; n++;
      end while (!ok && n < 100);
      if (!ok) fail_now("issue2_timeout");
      v2 = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q1.size() != 0 && n < 300) begin @(posedge clk); n++; end
      if (q1.size() != 0) fail_now("drain");
      @(posedge clk); #1;
   endtask

   // Main config: directed vectors, back-pressure, reset mid-flight.
   initial begin
      int  n;
      logic stream_done;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      i_a = '0; i_b = '0; i_c0 = 1'b0; i_sub = 1'b0; i_tag = '0;
      #1;
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_sum", {32'd0, o_sum}, 64'd0);
      chk("rst_ready", {63'd0, o_ready}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", {63'd0, o_ready}, 64'd1);

      pin("pin_wrap",  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      pin("pin_subov", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      pin("pin_neg",   32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      pin("pin_zero",  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      pin("pin_addov", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // Single op: latency counted in edges from the accepting edge.
      issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'hA5);
      n = 1;
      while (!o_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("latency", n, 64'd7);
      chk("wrap_sum_lit", {32'd0, o_sum}, 64'd0);
      chk("wrap_co_lit", {63'd0, o_c_out}, 64'd1);
      chk("wrap_tag_lit", {56'd0, o_tag}, 64'hA5);
      drain();

      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 8'h01);
      issue(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 8'h02);
      issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 8'h03);
      issue(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 8'h04);
      issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 8'h05);
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 8'h06);
      drain();

      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++)
               issue($urandom, $urandom, 1'($urandom), 1'($urandom), 8'(8'h40 + i));
         end
         begin
            repeat (10) @(posedge clk);
            #1 i_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 i_ready = 1'b1;
         end
      join
      drain();

      fork
         begin
            for (int i = 0; i < 150; i++)
               issue($urandom, $urandom, 1'($urandom), 1'($urandom), 8'(i));
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk); #1;
               i_ready = ($urandom_range(0, 3) != 0);
            end
            i_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 4; i++)
         issue(32'h1234_0000 + i, 32'h0000_1111, 1'b0, 1'b0, 8'hE0 + 8'(i));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {63'd0, o_valid}, 64'd0);
      chk("midrst_sum", {32'd0, o_sum}, 64'd0);
      chk("midrst_co", {63'd0, o_c_out}, 64'd0);
      chk("midrst_ovf", {63'd0, o_ovf}, 64'd0);
      chk("midrst_tag", {56'd0, o_tag}, 64'd0);
      q1.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rel_ready", {63'd0, o_ready}, 64'd1);
      repeat (15) @(posedge clk);
      #1 chk("no_stale", {63'd0, o_valid}, 64'd0);

      n = 0;
      while (!done2 && n < 5000) begin @(posedge clk); n++; end
      if (!done2) fail_now("dut2_done");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Second config: WIDTH=24, REG_EVERY=2, non-power-of-two width.
   initial begin
      int   n;
      logic sdone;
      rst2 = 1'b1; v2 = 1'b0; rdy2 = 1'b1;
      a2 = '0; b2 = '0; c02 = 1'b0; sub2 = 1'b0; tag2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst2 = 1'b0;
      @(posedge clk); #1;

      issue2(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 4'h9);
      n = 1;
      while (!ov2_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("latency2", n, 64'd5);
      chk("wrap2_sum_lit", {40'd0, sum2}, 64'd0);
      chk("wrap2_co_lit", {63'd0, co2}, 64'd1);
      repeat (3) @(posedge clk); #1;

      sdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++)
               issue2(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), 4'(i));
            sdone = 1'b1;
         end
         begin
            while (!sdone) begin
               @(posedge clk); #1;
               rdy2 = ($urandom_range(0, 2) != 0);
            end
            rdy2 = 1'b1;
         end
      join
      n = 0;
      while (q2.size() != 0 && n < 300) begin @(posedge clk); n++; end
      if (q2.size() != 0) fail_now("drain2");
      done2 = 1'b1;
   end

endmodule
